memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 64, effective-address width from execute.
REQ-002 SHALL have parameter DATA_WIDTH, 32, register and data-cache word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX/Mem register holds a live instruction.
- in_op  in  2  instruction op field; 2'b11 = memory format.
- in_op3  in  6  op3 field.
- in_addr  in  ADDR_WIDTH  ALU result: effective address, or result for non-memory ops.
- in_store_data  in  DATA_WIDTH  rd source value for stores.
- in_rd  in  5  destination register.
- mem_stall  out  1  freeze IF through EX/Mem.
- dc_req  out  1  data-cache request.
- dc_addr  out  ADDR_WIDTH  word-aligned address.
- dc_we  out  1  write enable.
- dc_be  out  4  byte enables; bit3 = byte lane 31:24.
- dc_wdata  out  DATA_WIDTH  lane-replicated store data.
- dc_ack  in  1  one-cycle completion.
- dc_rdata  in  DATA_WIDTH  read word, valid with dc_ack.
- wb_valid  out  1  one-cycle pulse to writeback.
- wb_we  out  1  write register file.
- wb_rd  out  5  destination register.
- wb_data  out  DATA_WIDTH  writeback value.
- trap  out  1  misaligned-access pulse.

Function
REQ-005 SHALL decode these memory ops when in_op==2'b11:
- loads: LD 0x00, LDUB 0x01, LDUH 0x02, LDSB 0x09, LDSH 0x0A.
- stores: ST 0x04, STB 0x05, STH 0x06.
- any other op3 with in_op==2'b11 is a non-memory op.
REQ-006 SHALL implement FSM IDLE -> ACCESS -> IDLE.
- IDLE with in_valid and a memory op: latch all inputs, go to ACCESS, set dc_req=1 on the next cycle.
REQ-007 SHALL hold dc_req, dc_addr, dc_we, dc_be and dc_wdata stable in ACCESS until a clock edge with dc_ack=1, then go to IDLE with dc_req=0.
REQ-008 SHALL assert mem_stall:
- combinationally in IDLE when in_valid and a memory op;
- in ACCESS while dc_ack=0;
- and SHALL drop it in the dc_ack cycle.
REQ-009 SHALL pulse wb_valid for exactly one cycle, on the edge after dc_ack; minimum memory-op latency is 2 cycles from acceptance.
REQ-010 SHALL pass non-memory valid ops through in 1 cycle with wb_data=in_addr[31:0], and SHALL NOT assert mem_stall for them.
REQ-011 SHALL use big-endian lane mapping.
- Byte at addr[1:0]=0 is dc_rdata[31:24].
- Halfword at addr[1]=0 is dc_rdata[31:16].
REQ-012 SHALL zero-extend LDUB/LDUH and sign-extend LDSB/LDSH to DATA_WIDTH.
REQ-013 SHALL drive dc_addr with in_addr, low two bits forced to 0.
- Store byte enables: ST 4'b1111, STH 4'b1100 or 4'b0011, STB one-hot.
- Store data replicated to every lane; loads use dc_be=4'b1111.
REQ-014 SHALL set wb_we=1 only for loads and non-memory ops with rd!=0; stores give wb_valid=1, wb_we=0.
REQ-015 SHALL ignore dc_ack in IDLE.
REQ-016 SHALL deassert all outputs when in_valid=0 in IDLE.

Reset
REQ-017 SHALL, on reset, on the same edge:
- drive every output to 0;
- force the FSM to IDLE;
- abandon any in-flight access without a writeback pulse.
REQ-018 SHALL ignore a dc_ack arriving in the cycle after reset.

Configuration
REQ-019 SHALL support MEM_ALIGN_TRAP_EN.
- When defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, pulses trap for one cycle, issues no dc_req, and gives wb_valid=0.
- When undefined: trap is tied to 0 and misaligned low bits are ignored, so the access uses the aligned containing lane(s).

Structure
REQ-020 SHALL take op3 constants, the FSM state enum and the access-size enum (BYTE, HALF, WORD) from the shared package sparc_mem_pkg.
REQ-021 SHALL place lane extract and sign extension in combinational sub-module load_align.

Verification
REQ-022 LDSB at addr 0x1003, dc_rdata 0x000000F0, ack after 3 cycles:
- expect wb_data 0xFFFFFFF0, wb_we=1;
- expect mem_stall high for 4 cycles.
REQ-023 STH at addr 0x2002, data 0x0000ABCD:
- expect dc_be 4'b0011, dc_wdata 0xABCDABCD, dc_addr 0x2000;
- expect wb_valid=1 with wb_we=0.
REQ-024 Non-memory op, in_addr 0x55, rd=3, followed by LD to rd=0:
- first: wb_data 0x55 one cycle later, no stall;
- second: wb_we=0.
REQ-025 LD at addr 0x1002:
- with MEM_ALIGN_TRAP_EN: one-cycle trap, no dc_req;
- without: dc_addr 0x1000, normal load.
REQ-026 Reset asserted during ACCESS, dc_ack in the next cycle:
- expect all outputs 0 and no wb_valid;
- expect the next LD to complete normally.

Source files
------------

// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC-style memory-access stage: op3 encodings,
// FSM state, access size and the memory-op decoder.
package sparc_mem_pkg;

    localparam logic [1:0] OpMem = 2'b11;

    localparam logic [5:0] Op3Ld   = 6'h00;
    localparam logic [5:0] Op3Ldub = 6'h01;
    localparam logic [5:0] Op3Lduh = 6'h02;
    localparam logic [5:0] Op3Ldsb = 6'h09;
    localparam logic [5:0] Op3Ldsh = 6'h0A;
    localparam logic [5:0] Op3St   = 6'h04;
    localparam logic [5:0] Op3Stb  = 6'h05;
    localparam logic [5:0] Op3Sth  = 6'h06;

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } size_e;

    typedef struct packed {
        logic  is_mem;
        logic  is_load;
        logic  sign_ext;
        size_e size;
    } mem_dec_t;

    // Classify an instruction; anything outside the memory table is non-memory.
    function automatic mem_dec_t decode_op(input logic [1:0] op, input logic [5:0] op3);
        mem_dec_t dec;
        dec = '{is_mem: 1'b0, is_load: 1'b0, sign_ext: 1'b0, size: SizeWord};
        if (op == OpMem) begin
            case (op3)
                Op3Ld:   dec = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SizeWord};
                Op3Ldub: dec = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SizeByte};
                Op3Lduh: dec = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SizeHalf};
                Op3Ldsb: dec = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b1, size: SizeByte};
                Op3Ldsh: dec = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b1, size: SizeHalf};
                Op3St:   dec = '{is_mem: 1'b1, is_load: 1'b0, sign_ext: 1'b0, size: SizeWord};
                Op3Stb:  dec = '{is_mem: 1'b1, is_load: 1'b0, sign_ext: 1'b0, size: SizeByte};
                Op3Sth:  dec = '{is_mem: 1'b1, is_load: 1'b0, sign_ext: 1'b0, size: SizeHalf};
                default: ;
            endcase
        end
        return dec;
    endfunction

    // Big-endian byte enables: bit3 is the lane at byte offset 0.
    function automatic logic [3:0] store_be(input size_e size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SizeByte: be = 4'b1000 >> lo;
            SizeHalf: be = lo[1] ? 4'b0011 : 4'b1100;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction (big-endian) and zero/sign extension to DATA_WIDTH.
module load_align
    import sparc_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  size_e                 size,
    input  logic                  sign_ext,
    input  logic [1:0]            lane,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword; offset 0 is the most significant lane.
    always_comb begin
        byte_sel = rdata[31:24];
        case (lane)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[15:0] : rdata[31:16];
    end

    // Extend the selected field to the register width.
    always_comb begin
        data = rdata;
        case (size)
            SizeByte: data = {{(DATA_WIDTH-8){sign_ext & byte_sel[7]}}, byte_sel};
            SizeHalf: data = {{(DATA_WIDTH-16){sign_ext & half_sel[15]}}, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one data-cache access per load/store,
// stalls the front of the pipe until dc_ack, and passes non-memory ops through.
// Optional feature macro: MEM_ALIGN_TRAP_EN (trap on misaligned half/word).
module memory_access
    import sparc_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [1:0]            in_op,
    input  logic [5:0]            in_op3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [4:0]            in_rd,
    output logic                  mem_stall,
    output logic                  dc_req,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic                  dc_we,
    output logic [3:0]            dc_be,
    output logic [DATA_WIDTH-1:0] dc_wdata,
    input  logic                  dc_ack,
    input  logic [DATA_WIDTH-1:0] dc_rdata,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  trap
);

    state_e                state_q, state_d;
    mem_dec_t              dec;
    logic                  misaligned;
    logic                  accept;
    logic                  in_access;
    logic                  ack_done;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] store_data_q;
    logic [4:0]            rd_q;
    logic                  is_load_q;
    logic                  sign_ext_q;
    size_e                 size_q;
    logic [DATA_WIDTH-1:0] load_data;

    logic                  wb_valid_q;
    logic                  wb_we_q;
    logic [4:0]            wb_rd_q;
    logic [DATA_WIDTH-1:0] wb_data_q;

    assign dec = decode_op(in_op, in_op3);

`ifdef MEM_ALIGN_TRAP_EN
    assign misaligned = ((dec.size == SizeHalf) && in_addr[0]) ||
                        ((dec.size == SizeWord) && (in_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign in_access = (state_q == StAccess);
    assign accept    = (state_q == StIdle) && in_valid && dec.is_mem && !misaligned;
    assign ack_done  = in_access && dc_ack;

    // Next-state: one access in flight at a time, retired by dc_ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: if (dc_ack) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register and capture of the accepted instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            is_load_q    <= 1'b0;
            sign_ext_q   <= 1'b0;
            size_q       <= SizeWord;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q       <= in_addr;
                store_data_q <= in_store_data;
                rd_q         <= in_rd;
                is_load_q    <= dec.is_load;
                sign_ext_q   <= dec.sign_ext;
                size_q       <= dec.size;
            end
        end
    end

    load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .size    (size_q),
        .sign_ext(sign_ext_q),
        .lane    (addr_q[1:0]),
        .rdata   (dc_rdata),
        .data    (load_data)
    );

    // Writeback pulse: memory ops retire the edge after dc_ack, others after one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            if (ack_done) begin
                wb_valid_q <= 1'b1;
                wb_we_q    <= is_load_q && (rd_q != 5'd0);
                wb_rd_q    <= rd_q;
                wb_data_q  <= is_load_q ? load_data : '0;
            end else if ((state_q == StIdle) && in_valid && !dec.is_mem) begin
                wb_valid_q <= 1'b1;
                wb_we_q    <= (in_rd != 5'd0);
                wb_rd_q    <= in_rd;
                wb_data_q  <= in_addr[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef MEM_ALIGN_TRAP_EN
    logic trap_q;

    // Misaligned access is dropped and reported as a single-cycle trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= (state_q == StIdle) && in_valid && dec.is_mem && misaligned;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Cache request driven purely from captured state, so it holds steady in ACCESS.
    always_comb begin
        dc_req   = in_access;
        dc_addr  = '0;
        dc_we    = 1'b0;
        dc_be    = 4'b0000;
        dc_wdata = '0;
        if (in_access) begin
            dc_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            dc_we   = !is_load_q;
            dc_be   = is_load_q ? 4'b1111 : store_be(size_q, addr_q[1:0]);
            if (!is_load_q) begin
                case (size_q)
                    SizeByte: dc_wdata = DATA_WIDTH'({4{store_data_q[7:0]}});
                    SizeHalf: dc_wdata = DATA_WIDTH'({2{store_data_q[15:0]}});
                    default:  dc_wdata = store_data_q;
                endcase
            end
        end
    end

    // Stall is released in the ack cycle so the pipe advances on the retiring edge.
    always_comb begin
        mem_stall = accept || (in_access && !dc_ack);
    end

    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios followed by
// randomized loads, stores and pass-through ops against a behavioural model.
module tb_memory_access;
    import sparc_mem_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [1:0]    in_op;
    logic [5:0]    in_op3;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_store_data;
    logic [4:0]    in_rd;
    logic          mem_stall;
    logic          dc_req;
    logic [AW-1:0] dc_addr;
    logic          dc_we;
    logic [3:0]    dc_be;
    logic [DW-1:0] dc_wdata;
    logic          dc_ack;
    logic [DW-1:0] dc_rdata;
    logic          wb_valid;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          trap;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_access #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_op3       (in_op3),
        .in_addr      (in_addr),
        .in_store_data(in_store_data),
        .in_rd        (in_rd),
        .mem_stall    (mem_stall),
        .dc_req       (dc_req),
        .dc_addr      (dc_addr),
        .dc_we        (dc_we),
        .dc_be        (dc_be),
        .dc_wdata     (dc_wdata),
        .dc_ack       (dc_ack),
        .dc_rdata     (dc_rdata),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .trap         (trap)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic bit model_is_mem(input logic [5:0] op3);
        return op3 inside {6'h00, 6'h01, 6'h02, 6'h09, 6'h0A, 6'h04, 6'h05, 6'h06};
    endfunction

    function automatic bit model_is_load(input logic [5:0] op3);
        return op3 inside {6'h00, 6'h01, 6'h02, 6'h09, 6'h0A};
    endfunction

    function automatic int model_size(input logic [5:0] op3);
        if (op3 inside {6'h00, 6'h04}) return 4;
        if (op3 inside {6'h02, 6'h0A, 6'h06}) return 2;
        return 1;
    endfunction

    // Byte offset of the accessed field inside its word (low bits below size ignored).
    function automatic int model_off(input logic [63:0] addr, input int sz);
        return (int'(addr[1:0]) / sz) * sz;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op3, input logic [63:0] addr,
                                               input logic [31:0] rdata);
        int     sz;
        int     off;
        longint v;
        sz  = model_size(op3);
        off = model_off(addr, sz);
        v   = longint'(rdata >> (8 * (4 - off - sz))) & ((longint'(1) << (8 * sz)) - 1);
        if ((op3 inside {6'h09, 6'h0A}) && (v >= (longint'(1) << (8 * sz - 1))))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op3, input logic [63:0] addr);
        logic [3:0] be;
        int         sz;
        int         off;
        if (model_is_load(op3)) return 4'b1111;
        sz  = model_size(op3);
        off = model_off(addr, sz);
        be  = 4'b0000;
        for (int i = off; i < off + sz; i++) be[3-i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op3, input logic [31:0] sdata);
        logic [31:0] w;
        int          sz;
        int          j;
        sz = model_size(op3);
        w  = '0;
        for (int i = 0; i < 4; i++) begin
            j = i % sz;
            w[8*(3-i) +: 8] = 8'(sdata >> (8 * (sz - 1 - j)));
        end
        return w;
    endfunction

    // ---------------- transaction tasks ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "/mem_stall"}, mem_stall, 0);
        check({tag, "/dc_req"}, dc_req, 0);
        check({tag, "/dc_addr"}, dc_addr, 0);
        check({tag, "/dc_we"}, dc_we, 0);
        check({tag, "/dc_be"}, dc_be, 0);
        check({tag, "/dc_wdata"}, dc_wdata, 0);
        check({tag, "/wb_valid"}, wb_valid, 0);
        check({tag, "/wb_we"}, wb_we, 0);
        check({tag, "/wb_rd"}, wb_rd, 0);
        check({tag, "/wb_data"}, wb_data, 0);
        check({tag, "/trap"}, trap, 0);
    endtask

    task automatic check_request(input string tag, input logic [5:0] op3,
                                 input logic [63:0] addr, input logic [31:0] sdata);
        bit ld;
        ld = model_is_load(op3);
        check({tag, "/dc_req"}, dc_req, 1);
        check({tag, "/dc_addr"}, dc_addr, {addr[63:2], 2'b00});
        check({tag, "/dc_we"}, dc_we, !ld);
        check({tag, "/dc_be"}, dc_be, model_be(op3, addr));
        if (!ld) check({tag, "/dc_wdata"}, dc_wdata, model_wdata(op3, sdata));
    endtask

    task automatic do_mem(input string tag, input logic [5:0] op3, input logic [63:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd,
                          input int wait_cycles, input logic [31:0] rdata);
        bit ld;
        int stalls;
        ld     = model_is_load(op3);
        stalls = 0;
        in_valid = 1'b1; in_op = 2'b11; in_op3 = op3; in_addr = addr;
        in_store_data = sdata; in_rd = rd; dc_ack = 1'b0;
        #1;
        check({tag, "/accept_stall"}, mem_stall, 1);
        check({tag, "/accept_no_req"}, dc_req, 0);
        if (mem_stall) stalls++;
        tick();
        for (int c = 0; c < wait_cycles; c++) begin
            dc_rdata = $urandom();
            #1;
            check_request({tag, "/wait"}, op3, addr, sdata);
            check({tag, "/wait_stall"}, mem_stall, 1);
            if (mem_stall) stalls++;
            tick();
        end
        dc_ack = 1'b1; dc_rdata = rdata;
        #1;
        check_request({tag, "/ack"}, op3, addr, sdata);
        check({tag, "/ack_stall"}, mem_stall, 0);
        if (mem_stall) stalls++;
        tick();
        dc_ack = 1'b0; in_valid = 1'b0;
        check({tag, "/stall_cycles"}, stalls, wait_cycles + 1);
        check({tag, "/wb_valid"}, wb_valid, 1);
        check({tag, "/wb_we"}, wb_we, ld && (rd != 5'd0));
        if (ld) begin
            check({tag, "/wb_rd"}, wb_rd, rd);
            check({tag, "/wb_data"}, wb_data, model_load(op3, addr, rdata));
        end
        check({tag, "/req_dropped"}, dc_req, 0);
        check({tag, "/trap"}, trap, 0);
        tick();
        check({tag, "/wb_pulse_end"}, wb_valid, 0);
    endtask

    // Leaves in_valid asserted so a following op can issue back-to-back.
    task automatic do_nonmem(input string tag, input logic [1:0] op, input logic [5:0] op3,
                             input logic [63:0] addr, input logic [4:0] rd);
        in_valid = 1'b1; in_op = op; in_op3 = op3; in_addr = addr;
        in_store_data = $urandom(); in_rd = rd; dc_ack = 1'b0;
        #1;
        check({tag, "/no_stall"}, mem_stall, 0);
        check({tag, "/no_req"}, dc_req, 0);
        tick();
        check({tag, "/wb_valid"}, wb_valid, 1);
        check({tag, "/wb_we"}, wb_we, rd != 5'd0);
        check({tag, "/wb_rd"}, wb_rd, rd);
        check({tag, "/wb_data"}, wb_data, addr[31:0]);
    endtask

    // ---------------- stimulus ----------------
    logic [5:0]  mem_ops [8];
    logic [5:0]  r_op3;
    logic [1:0]  r_op;
    logic [63:0] r_addr;
    logic [31:0] r_data;
    int          r_sz;

    initial begin
        mem_ops = '{6'h00, 6'h01, 6'h02, 6'h09, 6'h0A, 6'h04, 6'h05, 6'h06};
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_op3 = '0; in_addr = '0;
        in_store_data = '0; in_rd = '0; dc_ack = 1'b0; dc_rdata = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Stray ack while idle must have no effect.
        dc_ack = 1'b1; dc_rdata = 32'hDEADBEEF;
        tick();
        dc_ack = 1'b0;
        check_all_zero("idle_ack");

        do_mem("ldsb_1003", 6'h09, 64'h1003, 32'h0, 5'd7, 3, 32'h000000F0);
        do_mem("sth_2002", 6'h06, 64'h2002, 32'h0000ABCD, 5'd4, 0, 32'h0);

        do_nonmem("alu_55", 2'b10, 6'h00, 64'h55, 5'd3);
        do_mem("ld_rd0", 6'h00, 64'h1000, 32'h0, 5'd0, 1, 32'h12345678);

`ifdef MEM_ALIGN_TRAP_EN
        in_valid = 1'b1; in_op = 2'b11; in_op3 = 6'h00; in_addr = 64'h1002; in_rd = 5'd2;
        #1;
        check("trap/no_req_idle", dc_req, 0);
        tick();
        in_valid = 1'b0;
        check("trap/pulse", trap, 1);
        check("trap/no_req", dc_req, 0);
        check("trap/no_wb", wb_valid, 0);
        tick();
        check("trap/pulse_end", trap, 0);
        check("trap/no_req_after", dc_req, 0);
        check("trap/no_wb_after", wb_valid, 0);
`else
        do_mem("ld_1002", 6'h00, 64'h1002, 32'h0, 5'd2, 1, 32'hCAFEF00D);
`endif

        // Reset while an access is outstanding, with a late ack right after.
        in_valid = 1'b1; in_op = 2'b11; in_op3 = 6'h00; in_addr = 64'h3000; in_rd = 5'd5;
        tick();
        check("rst_access/req", dc_req, 1);
        in_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; dc_ack = 1'b1; dc_rdata = 32'h11223344;
        #1;
        check_all_zero("rst_access/after");
        tick();
        dc_ack = 1'b0;
        check_all_zero("rst_access/late_ack");
        do_mem("ld_after_rst", 6'h00, 64'h3004, 32'h0, 5'd5, 0, 32'h89ABCDEF);

        for (int it = 0; it < 40; it++) begin
            r_addr = {$urandom(), $urandom()};
            if ($urandom_range(0, 2) == 0) begin
                r_op = 2'($urandom_range(0, 3));
                r_op3 = 6'($urandom());
                if (r_op == 2'b11)
                    while (model_is_mem(r_op3)) r_op3 = 6'($urandom());
                do_nonmem("rand_alu", r_op, r_op3, r_addr, 5'($urandom()));
            end else begin
                r_op3 = mem_ops[$urandom_range(0, 7)];
                r_sz  = model_size(r_op3);
`ifdef MEM_ALIGN_TRAP_EN
                r_addr = r_addr & ~64'(r_sz - 1);
`endif
                r_data = $urandom();
                do_mem("rand_mem", r_op3, r_addr, r_data, 5'($urandom()),
                       $urandom_range(0, 3), $urandom());
            end
        end
        in_valid = 1'b0;
        tick();
        check("final_idle/wb_valid", wb_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
